// File: rtl/jtdsp16_prog.sv
// jtdsp16_prog: ROM loader for the DSP16 core.
// Packs a host byte stream into 16-bit words and writes them to the
// core's internal ROM at consecutive addresses, one write strobe per word.
// Also reports progress (busy/done), late bytes (overflow) and a running
// modulo-2^16 checksum of every word written since the last start.
module jtdsp16_prog #(
    parameter int AW       = 12,
    parameter int WORDS    = 4096,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    dl_data,
    input  logic          dl_valid,
    output logic          dl_ready,
    output logic [AW-1:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic          prog_we,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [15:0]   checksum
);

    // The word counter must be able to hold WORDS itself, hence the +1.
    localparam int            CW   = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        BYTE0,
        BYTE1,
        WRITE,
        FULL
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic          handshake;

    // dl_ready is itself a register, so a handshake only depends on it
    // and on the host's valid.
    assign handshake = dl_valid & dl_ready;

    // Loader FSM; every output is a register updated alongside the state.
    // prog_data is assembled in place: the first byte lands in its half
    // while prog_we is low, the second completes the word on entry to WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_we   <= 1'b0;
            dl_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            checksum  <= '0;
        end else if (start) begin
            // Restart from any state; a pending half word is simply dropped.
            state_reg <= BYTE0;
            count_reg <= '0;
            prog_addr <= '0;
            prog_we   <= 1'b0;
            dl_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            overflow  <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    prog_we <= 1'b0;
                end
                BYTE0: begin
                    if (handshake) begin
                        if (HI_FIRST) prog_data[15:8] <= dl_data;
                        else          prog_data[7:0]  <= dl_data;
                        state_reg <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (handshake) begin
                        if (HI_FIRST) prog_data[7:0]  <= dl_data;
                        else          prog_data[15:8] <= dl_data;
                        state_reg <= WRITE;
                        dl_ready  <= 1'b0;
                        prog_we   <= 1'b1;
                    end
                end
                WRITE: begin
                    prog_we   <= 1'b0;
                    checksum  <= checksum + prog_data;
                    count_reg <= count_reg + CW'(1);
                    dl_ready  <= 1'b1;
                    if (count_reg == LAST) begin
                        // Image complete: address stays on the last word.
                        state_reg <= FULL;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        prog_addr <= prog_addr + AW'(1);
                        state_reg <= BYTE0;
                    end
                end
                FULL: begin
                    // Late bytes are swallowed so the host never stalls.
                    if (handshake) overflow <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    prog_we   <= 1'b0;
                    dl_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdsp16_prog.sv
// Bench for jtdsp16_prog: two instances (high-byte-first and low-byte-first,
// different image sizes) share one stimulus stream and are compared every
// cycle against a transaction-level model of the loader.
module tb_jtdsp16_prog;

    localparam int AW_A = 2;
    localparam int WA   = 4;
    localparam int HA   = 1;
    localparam int AW_B = 3;
    localparam int WB   = 5;
    localparam int HB   = 0;

    logic clk = 1'b0;
    logic rst, start, dl_valid;
    logic [7:0] dl_data;

    logic            ready_a, we_a, busy_a, done_a, ovf_a;
    logic [AW_A-1:0] addr_a;
    logic [15:0]     data_a, csum_a;
    logic            ready_b, we_b, busy_b, done_b, ovf_b;
    logic [AW_B-1:0] addr_b;
    logic [15:0]     data_b, csum_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtdsp16_prog #(.AW(AW_A), .WORDS(WA), .HI_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .dl_data(dl_data),
        .dl_valid(dl_valid), .dl_ready(ready_a), .prog_addr(addr_a),
        .prog_data(data_a), .prog_we(we_a), .busy(busy_a), .done(done_a),
        .overflow(ovf_a), .checksum(csum_a)
    );

    jtdsp16_prog #(.AW(AW_B), .WORDS(WB), .HI_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .dl_data(dl_data),
        .dl_valid(dl_valid), .dl_ready(ready_b), .prog_addr(addr_b),
        .prog_data(data_b), .prog_we(we_b), .busy(busy_b), .done(done_b),
        .overflow(ovf_b), .checksum(csum_b)
    );

    // Reference model state, one slot per instance.
    int          m_active[2];
    int          m_full[2];
    int          m_have[2];
    int          m_wcount[2];
    int          m_wr[2];
    int          m_ovf[2];
    logic [7:0]  m_half[2];
    logic [15:0] m_csum[2];
    logic [15:0] m_word[2];
    int          hs_b;
    logic [7:0]  bq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int words_of(input int d);
        return (d == 0) ? WA : WB;
    endfunction

    function automatic int hi_of(input int d);
        return (d == 0) ? HA : HB;
    endfunction

    function automatic int exp_ready(input int d);
        return ((m_active[d] != 0 && m_wr[d] == 0) || m_full[d] != 0) ? 1 : 0;
    endfunction

    task automatic model_reset(input int d);
        m_active[d] = 0; m_full[d] = 0; m_have[d] = 0; m_wcount[d] = 0;
        m_wr[d] = 0; m_ovf[d] = 0; m_half[d] = 8'h00; m_csum[d] = 16'h0000;
        m_word[d] = 16'h0000;
    endtask

    task automatic compare(input int d);
        logic        rdy, we, bsy, dn, ov;
        logic [31:0] addr;
        logic [15:0] data, cs;
        int          exp_addr;
        if (d == 0) begin
            rdy = ready_a; we = we_a; bsy = busy_a; dn = done_a; ov = ovf_a;
            addr = 32'(addr_a); data = data_a; cs = csum_a;
        end else begin
            rdy = ready_b; we = we_b; bsy = busy_b; dn = done_b; ov = ovf_b;
            addr = 32'(addr_b); data = data_b; cs = csum_b;
        end
        exp_addr = (m_full[d] != 0) ? words_of(d) - 1 : m_wcount[d];
        check($sformatf("dut%0d_we", d), 32'(we), 32'(m_wr[d]));
        check($sformatf("dut%0d_ready", d), 32'(rdy), 32'(exp_ready(d)));
        check($sformatf("dut%0d_busy", d), 32'(bsy), 32'(m_active[d]));
        check($sformatf("dut%0d_done", d), 32'(dn), 32'(m_full[d]));
        check($sformatf("dut%0d_overflow", d), 32'(ov), 32'(m_ovf[d]));
        check($sformatf("dut%0d_checksum", d), 32'(cs), 32'(m_csum[d]));
        check($sformatf("dut%0d_addr", d), addr, 32'(exp_addr));
        if (m_wr[d] != 0) begin
            check($sformatf("dut%0d_data", d), 32'(data), 32'(m_word[d]));
            $display("dut%0d write addr=%0d data=%04h", d, exp_addr, m_word[d]);
        end
    endtask

    // Advance the model by one clock edge given the inputs being driven.
    task automatic model_step(input int d, input logic r, input logic s,
                              input logic v, input logic [7:0] b);
        int acc;
        acc = (v && exp_ready(d) != 0) ? 1 : 0;
        if (d == 1) hs_b = 0;
        if (r) begin
            model_reset(d);
        end else if (s) begin
            m_active[d] = 1; m_full[d] = 0; m_have[d] = 0; m_wcount[d] = 0;
            m_csum[d] = 16'h0000; m_ovf[d] = 0; m_wr[d] = 0;
        end else if (m_wr[d] != 0) begin
            m_csum[d] = m_csum[d] + m_word[d];
            m_wcount[d]++;
            m_wr[d] = 0;
            if (m_wcount[d] == words_of(d)) begin
                m_active[d] = 0;
                m_full[d]   = 1;
            end
        end else if (acc != 0) begin
            if (d == 1) hs_b = 1;
            if (m_full[d] != 0) begin
                m_ovf[d] = 1;
            end else if (m_have[d] == 0) begin
                m_half[d] = b;
                m_have[d] = 1;
            end else begin
                m_word[d] = (hi_of(d) != 0) ? {m_half[d], b} : {b, m_half[d]};
                m_wr[d]   = 1;
                m_have[d] = 0;
            end
        end
    endtask

    // One clock: check outputs away from the edge, then drive the next inputs.
    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] b);
        @(negedge clk);
        compare(0);
        compare(1);
        rst = r; start = s; dl_valid = v; dl_data = b;
        model_step(0, r, s, v, b);
        model_step(1, r, s, v, b);
    endtask

    task automatic feed(input int pct, input int start_pct, input int budget);
        int  n;
        logic v, s;
        n = 0;
        while (bq.size() > 0 && n < budget) begin
            v = ($urandom_range(99) < pct);
            s = ($urandom_range(999) < start_pct);
            step(1'b0, s, v, v ? bq[0] : 8'($urandom));
            if (hs_b != 0) void'(bq.pop_front());
            n++;
        end
        if (bq.size() != 0) begin
            check("feed_budget", 32'(bq.size()), 32'd0);
            bq.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; dl_valid = 1'b0; dl_data = 8'h00;
        repeat (2) @(posedge clk);
        model_reset(0);
        model_reset(1);

        // Reset values, then idle with valid high: nothing accepted.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h66);

        // Basic load of two words, back to back.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        bq = '{8'h12, 8'h34, 8'h56, 8'h78};
        feed(100, 0, 40);
        idle(3);
        check("csum_a_68ac", 32'(csum_a), 32'h68AC);
        check("csum_b_ac68", 32'(csum_b), 32'hAC68);
        check("done_a_low", 32'(done_a), 32'd0);
        check("busy_a_high", 32'(busy_a), 32'd1);

        // Full image on the small instance, checksum wraps to zero.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        bq = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h00, 8'h80, 8'h00};
        feed(100, 0, 60);
        idle(3);
        check("full_a_done", 32'(done_a), 32'd1);
        check("full_a_busy", 32'(busy_a), 32'd0);
        check("full_a_addr", 32'(addr_a), 32'd3);
        check("full_a_csum", 32'(csum_a), 32'h0000);
        bq = '{8'hA5};
        feed(100, 0, 20);
        idle(2);
        check("full_a_overflow", 32'(ovf_a), 32'd1);
        bq = '{8'h11, 8'h22, 8'h33};
        feed(100, 0, 30);
        idle(3);

        // Restart mid-word: the half word is dropped, reload at address 0.
        // Start coincides with a valid byte, which must not be consumed.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        bq = '{8'hDE, 8'hAD, 8'hBE};
        feed(100, 0, 30);
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        bq = '{8'h01, 8'h02};
        feed(100, 0, 30);
        idle(3);
        check("restart_a_csum", 32'(csum_a), 32'h0102);
        check("restart_b_csum", 32'(csum_b), 32'h0201);

        // Randomised rounds: gappy valid, occasional restarts, overrun bytes.
        for (int r = 0; r < 12; r++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            for (int i = 0; i < 2 * WB + 1 + int'($urandom_range(4)); i++)
                bq.push_back(8'($urandom));
            feed(int'($urandom_range(30, 100)), (r % 3 == 2) ? 20 : 0, 400);
            idle(3);
        end

        // Reset during the write cycle.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        bq = '{8'h9A, 8'hBC};
        n = 0;
        while (m_wr[1] == 0 && n < 20) begin
            step(1'b0, 1'b0, 1'b1, bq.size() > 0 ? bq[0] : 8'h00);
            if (hs_b != 0 && bq.size() > 0) void'(bq.pop_front());
            n++;
        end
        check("reach_write", 32'(m_wr[1]), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h77);
        check("rst_we_a", 32'(we_a), 32'd0);
        check("rst_ready_a", 32'(ready_a), 32'd0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
